// File: rtl/lif_pkg.sv
// lif_pkg: shared FSM states, widths and saturation helper for the LIF spike path
package lif_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  localparam int SPIKE_CNT_W = 16;
  localparam int I_WIDTH_DEF = 8;
  function automatic logic [63:0] clamp(input logic signed [63:0] v, input logic [62:0] hi);
    return v < 0 ? 64'd0 : v > $signed({1'b0, hi}) ? {1'b0, hi} : v;
  endfunction
endpackage

// File: rtl/lif_spike_edge_det.sv
// lif_spike_edge_det: N-wide rising-edge spike detector with popcount of detected edges
module lif_spike_edge_det #(
  parameter int N = 4,
  parameter int CW = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  spike_in,
  output logic [N-1:0]  det,
  output logic [CW-1:0] count
);
  logic [N-1:0] spike_prev;
  always_ff @(posedge clk) spike_prev <= reset ? '0 : spike_in;
  assign det = spike_in & ~spike_prev;
  always_comb begin
    count = '0;
    for (int i = 0; i < N; i++) count = count + CW'(det[i]);
  end
endmodule

// File: rtl/lif_spike_synapse.sv
// lif_spike_synapse: weighted leaky spike integrator driving neuron I_app; INHIBITORY_EN selects signed weights
module lif_spike_synapse
  import lif_pkg::*;
#(
  parameter int N_IN = 4,
  parameter int W_WIDTH = 8,
  parameter int ACC_WIDTH = 16,
  parameter int I_WIDTH = I_WIDTH_DEF,
  parameter int DECAY_PERIOD = 4,
  parameter int DECAY_SHIFT = 3,
  localparam int AW = N_IN > 1 ? $clog2(N_IN) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [N_IN-1:0]        spike_in,
  input  logic                   w_wr_en,
  input  logic [AW-1:0]          w_addr,
  input  logic [W_WIDTH-1:0]     w_data,
  output logic [I_WIDTH-1:0]     I_app,
  output logic                   i_sat,
  output logic                   busy,
  output logic [SPIKE_CNT_W-1:0] spike_count
);
  localparam int CW = $clog2(N_IN + 1);
  localparam int SW = ACC_WIDTH + CW + 2;
  localparam int PW = DECAY_PERIOD > 1 ? $clog2(DECAY_PERIOD) : 1;
  localparam logic [62:0] ACC_MAX = (63'd1 << ACC_WIDTH) - 63'd1;
  localparam logic [62:0] I_MAX = (63'd1 << I_WIDTH) - 63'd1;
`ifdef INHIBITORY_EN
  localparam bit SIGNED_W = 1'b1;
`else
  localparam bit SIGNED_W = 1'b0;
`endif
  state_t state, state_next;
  logic [ACC_WIDTH-1:0] acc, acc_next, leak;
  logic [PW-1:0] pre;
  logic [W_WIDTH-1:0] w [N_IN];
  logic [N_IN-1:0] det;
  logic [CW-1:0] det_count;
  logic signed [SW-1:0] sum, raw;
  logic tick;
  lif_spike_edge_det #(.N(N_IN)) u_edge (
    .clk(clk),
    .reset(reset),
    .spike_in(spike_in),
    .det(det),
    .count(det_count)
  );
  assign tick = state != IDLE && pre == PW'(DECAY_PERIOD - 1);
  assign busy = state != IDLE;
  always_comb begin
    sum = '0;
    for (int i = 0; i < N_IN; i++)
      sum = sum + (det[i] && state == RUN ? (SIGNED_W ? SW'($signed(w[i])) : SW'(w[i])) : '0);
    leak = !tick ? '0 : acc >= ACC_WIDTH'(1 << DECAY_SHIFT) ? acc >> DECAY_SHIFT : ACC_WIDTH'(acc != '0);
    raw = SW'(acc) - SW'(leak) + sum;
    acc_next = state == IDLE ? '0 : ACC_WIDTH'(clamp(64'(raw), ACC_MAX));
    state_next = state == IDLE ? (enable ? RUN : IDLE)
               : state == RUN ? (enable ? RUN : DRAIN)
               : enable ? RUN : acc == '0 ? IDLE : DRAIN;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      acc <= '0;
      pre <= '0;
      I_app <= '0;
      i_sat <= 1'b0;
      spike_count <= '0;
      for (int i = 0; i < N_IN; i++) w[i] <= '0;
    end else begin
      state <= state_next;
      acc <= acc_next;
      pre <= state == IDLE || tick ? '0 : pre + 1'b1;
      I_app <= I_WIDTH'(clamp(64'(acc_next), I_MAX));
      i_sat <= 63'(acc_next) > I_MAX;
      if (state == RUN) spike_count <= spike_count + SPIKE_CNT_W'(det_count);
      if (w_wr_en && int'(w_addr) < N_IN) w[w_addr] <= w_data;
    end
  end
endmodule
